// File: rtl/playback_control.sv
// Button sequencer for the note-storage datapath: records notes, counts them and
// steps the playback slot at a fixed beat rate.
module playback_control #(
    parameter int BEAT_TICKS = 12_500_000,
    parameter int SLOTS      = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_record_req,
    input  logic       i_play_req,
    input  logic       i_stop_req,
    input  logic       i_clear_req,
    input  logic       i_loop_en,
    output logic       o_ld_note,
    output logic       o_ld_play,
    output logic [3:0] o_note_counter,
    output logic       o_display_note,
    output logic       o_busy,
    output logic       o_play_done,
    output logic [4:0] o_note_count
);

    localparam int          BW        = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_TICKS - 1);
    localparam logic [4:0]  MAX_COUNT = 5'(SLOTS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    logic [1:0]    r_state;
    logic          r_rec_prev, r_play_prev, r_stop_prev, r_clear_prev;
    logic          r_ld_note, r_ld_play, r_display_note, r_busy, r_play_done;
    logic [3:0]    r_note_counter;
    logic [4:0]    r_note_count;
    logic [BW-1:0] r_beat;

    logic w_rec_edge, w_play_edge, w_stop_edge, w_clear_edge;
    logic w_last_slot, w_beat_end;

    assign w_rec_edge   = i_record_req & ~r_rec_prev;
    assign w_play_edge  = i_play_req   & ~r_play_prev;
    assign w_stop_edge  = i_stop_req   & ~r_stop_prev;
    assign w_clear_edge = i_clear_req  & ~r_clear_prev;

    // Last stored slot: counter + 1 has reached the number of stored notes.
    assign w_last_slot = ({1'b0, r_note_counter} + 5'd1) >= r_note_count;
    assign w_beat_end  = (r_beat == BEAT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_IDLE;
            r_rec_prev     <= 1'b0;
            r_play_prev    <= 1'b0;
            r_stop_prev    <= 1'b0;
            r_clear_prev   <= 1'b0;
            r_ld_note      <= 1'b0;
            r_ld_play      <= 1'b0;
            r_display_note <= 1'b0;
            r_busy         <= 1'b0;
            r_play_done    <= 1'b0;
            r_note_counter <= 4'd0;
            r_note_count   <= 5'd0;
            r_beat         <= '0;
        end else begin
            r_rec_prev     <= i_record_req;
            r_play_prev    <= i_play_req;
            r_stop_prev    <= i_stop_req;
            r_clear_prev   <= i_clear_req;
            r_ld_note      <= 1'b0;
            r_display_note <= 1'b0;
            r_play_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // clear > play > record; losing edges are dropped
                    if (w_clear_edge) begin
                        r_note_count <= 5'd0;
                    end else if (w_play_edge) begin
                        if (r_note_count != 5'd0) begin
                            r_state        <= ST_PLAY;
                            r_ld_play      <= 1'b1;
                            r_busy         <= 1'b1;
                            r_display_note <= 1'b1;
                            r_note_counter <= 4'd0;
                            r_beat         <= '0;
                        end
                    end else if (w_rec_edge) begin
                        r_state   <= ST_REC;
                        r_ld_note <= 1'b1;
                        if (r_note_count != MAX_COUNT) begin
                            r_note_count <= r_note_count + 5'd1;
                        end
                    end
                end
                ST_REC: begin
                    r_state <= ST_IDLE;
                end
                ST_PLAY: begin
                    if (w_stop_edge || (w_beat_end && w_last_slot && !i_loop_en)) begin
                        r_state        <= ST_IDLE;
                        r_ld_play      <= 1'b0;
                        r_busy         <= 1'b0;
                        r_play_done    <= 1'b1;
                        r_note_counter <= 4'd0;
                        r_beat         <= '0;
                    end else if (w_beat_end) begin
                        r_note_counter <= w_last_slot ? 4'd0 : r_note_counter + 4'd1;
                        r_display_note <= 1'b1;
                        r_beat         <= '0;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ld_note      = r_ld_note;
    assign o_ld_play      = r_ld_play;
    assign o_note_counter = r_note_counter;
    assign o_display_note = r_display_note;
    assign o_busy         = r_busy;
    assign o_play_done    = r_play_done;
    assign o_note_count   = r_note_count;

endmodule

// File: tb/tb_playback_control.sv
// Directed bench for playback_control with BEAT_TICKS=4: recording, playback,
// looping, stop, clear, saturation and asynchronous reset.
module tb_playback_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       record_req = 1'b0, play_req = 1'b0, stop_req = 1'b0, clear_req = 1'b0;
    logic       loop_en = 1'b0;
    logic       ld_note, ld_play, display_note, busy, play_done;
    logic [3:0] note_counter;
    logic [4:0] note_count;

    int tests = 0;
    int fails = 0;

    playback_control #(.BEAT_TICKS(4), .SLOTS(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_record_req   (record_req),
        .i_play_req     (play_req),
        .i_stop_req     (stop_req),
        .i_clear_req    (clear_req),
        .i_loop_en      (loop_en),
        .o_ld_note      (ld_note),
        .o_ld_play      (ld_play),
        .o_note_counter (note_counter),
        .o_display_note (display_note),
        .o_busy         (busy),
        .o_play_done    (play_done),
        .o_note_count   (note_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ld_note"}, 32'(ld_note), 32'd0);
        chk({tag, "_ld_play"}, 32'(ld_play), 32'd0);
        chk({tag, "_counter"}, 32'(note_counter), 32'd0);
        chk({tag, "_display"}, 32'(display_note), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(play_done), 32'd0);
    endtask

    initial begin
        // reset held through a few edges
        step(); step();
        chk_idle_outs("rst");
        chk("rst_count", 32'(note_count), 32'd0);
        reset = 1'b1;
        step();
        chk_idle_outs("post_rst");

        // three record edges, 4 cycles apart
        for (int i = 0; i < 3; i++) begin
            record_req = 1'b1;
            step();
            chk("rec_ld_note", 32'(ld_note), 32'd1);
            chk("rec_count", 32'(note_count), 32'(i + 1));
            record_req = 1'b0;
            step();
            chk("rec_ld_note_low", 32'(ld_note), 32'd0);
            chk("rec_ld_play", 32'(ld_play), 32'd0);
            step(); step();
        end

        // non-loop playback of 3 slots
        loop_en  = 1'b0;
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk("play_ld", 32'(ld_play), 32'd1);
            chk("play_busy", 32'(busy), 32'd1);
            chk("play_cnt", 32'(note_counter), 32'((c - 1) / 4));
            chk("play_disp", 32'(display_note), 32'(((c - 1) % 4) == 0));
            chk("play_done_low", 32'(play_done), 32'd0);
            step();
        end
        chk("end_ld", 32'(ld_play), 32'd0);
        chk("end_done", 32'(play_done), 32'd1);
        chk("end_cnt", 32'(note_counter), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        step();
        chk("end_done_once", 32'(play_done), 32'd0);
        step();

        // looping playback, then stop during slot 1 of the second pass
        loop_en  = 1'b1;
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk("loop_ld", 32'(ld_play), 32'd1);
            chk("loop_cnt", 32'(note_counter), 32'(((c - 1) / 4) % 3));
            chk("loop_disp", 32'(display_note), 32'(((c - 1) % 4) == 0));
            chk("loop_done_low", 32'(play_done), 32'd0);
            if (c == 18) stop_req = 1'b1;
            step();
        end
        chk("stop_ld", 32'(ld_play), 32'd0);
        chk("stop_done", 32'(play_done), 32'd1);
        chk("stop_cnt", 32'(note_counter), 32'd0);
        stop_req = 1'b0;
        loop_en  = 1'b0;
        step();
        chk("stop_done_once", 32'(play_done), 32'd0);

        // clear and play together: clear wins, no playback
        clear_req = 1'b1;
        play_req  = 1'b1;
        step();
        chk("clr_count", 32'(note_count), 32'd0);
        chk("clr_ld_play", 32'(ld_play), 32'd0);
        clear_req = 1'b0;
        play_req  = 1'b0;
        step();
        chk_idle_outs("clr_after");
        // play with zero notes is ignored
        play_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("empty_ld_play", 32'(ld_play), 32'd0);
            chk("empty_done", 32'(play_done), 32'd0);
        end
        play_req = 1'b0;
        step();

        // 17 records: count saturates at 16, last ld_note still pulses
        for (int i = 1; i <= 17; i++) begin
            record_req = 1'b1;
            step();
            chk("sat_ld_note", 32'(ld_note), 32'd1);
            chk("sat_count", 32'(note_count), 32'((i > 16) ? 16 : i));
            record_req = 1'b0;
            step();
        end

        // full 16-slot playback with play_req held high past the end
        play_req = 1'b1;
        step();
        for (int c = 1; c <= 64; c++) begin
            chk("full_ld", 32'(ld_play), 32'd1);
            chk("full_cnt", 32'(note_counter), 32'((c - 1) / 4));
            chk("full_disp", 32'(display_note), 32'(((c - 1) % 4) == 0));
            step();
        end
        chk("full_done", 32'(play_done), 32'd1);
        chk("full_cnt_end", 32'(note_counter), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("held_no_retrigger", 32'(ld_play), 32'd0);
            chk("held_no_done", 32'(play_done), 32'd0);
        end
        play_req = 1'b0;
        step();

        // asynchronous reset mid-play at slot 1
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        step(); step(); step(); step();
        chk("pre_rst_cnt", 32'(note_counter), 32'd1);
        chk("pre_rst_ld", 32'(ld_play), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle_outs("async_rst");
        chk("async_rst_count", 32'(note_count), 32'd0);
        step();
        chk("rst_no_done", 32'(play_done), 32'd0);
        reset = 1'b1;
        step();
        chk("rel_count", 32'(note_count), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        record_req = 1'b1;
        step();
        chk("rel_rec", 32'(ld_note), 32'd1);
        chk("rel_rec_count", 32'(note_count), 32'd1);
        record_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
